// File: rtl/conv_window_tagger.sv
// rtl/conv_window_tagger.sv - 13-slot circular sample buffer emitting tag-indexed window words
module conv_window_tagger #(
    parameter int WIN    = 13,
    parameter int STRIDE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [19:0] data_out0,
    output logic [19:0] data_out1,
    output logic [19:0] data_out2,
    output logic [19:0] data_out3,
    output logic [19:0] data_out4,
    output logic [19:0] data_out5,
    output logic [19:0] data_out6,
    output logic [19:0] data_out7,
    output logic [19:0] data_out8,
    output logic [19:0] data_out9,
    output logic [19:0] data_out10,
    output logic [19:0] data_out11,
    output logic [19:0] data_out12
);
    localparam int         DEPTH    = 13;
    localparam logic [3:0] L_DEPTH  = 4'd13;
    localparam logic [3:0] L_LAST   = 4'd12;
    localparam logic [3:0] L_WIN    = 4'(WIN);
    localparam logic [3:0] L_STRIDE = 4'(STRIDE);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0]  r_state;
    logic [3:0]  r_wr_ptr;
    logic [3:0]  r_fill;
    logic [3:0]  r_stride_cnt;
    logic        r_line_end;
    logic [15:0] r_slot [DEPTH];
    logic [19:0] r_dout [DEPTH];

    logic        w_accept;
    logic [3:0]  w_ptr_next;
    logic [3:0]  w_fill_next;
    logic [3:0]  w_stride_next;
    logic        w_fire;
    logic [19:0] w_win [DEPTH];
    logic [4:0]  v_age;
    logic [3:0]  v_tag;
    logic [15:0] v_data;

    assign s_ready  = !rst && (r_state == S_FILL);
    assign m_valid  = (r_state == S_EMIT);
    assign w_accept = s_valid && s_ready;

    always_comb begin
        w_ptr_next    = (r_wr_ptr == L_LAST) ? 4'd0 : r_wr_ptr + 4'd1;
        w_fill_next   = (r_fill == L_DEPTH) ? L_DEPTH : r_fill + 4'd1;
        w_stride_next = r_stride_cnt + 4'd1;
        // First window of a line is the accept that brings fill up to WIN; later ones follow the stride.
        w_fire        = (w_fill_next >= L_WIN) && ((r_fill < L_WIN) || (w_stride_next == L_STRIDE));
        v_age  = 5'd0;
        v_tag  = 4'd0;
        v_data = 16'd0;
        for (int s = 0; s < DEPTH; s++) begin
            v_age = {1'b0, w_ptr_next} + 5'd12 - 5'(s);
            if (v_age >= 5'd13) begin
                v_age = v_age - 5'd13;
            end
            v_data = (r_wr_ptr == 4'(s)) ? s_data : r_slot[s];
            v_tag  = ((v_age < {1'b0, L_WIN}) && (v_age < {1'b0, w_fill_next})) ? (L_WIN - v_age[3:0]) : 4'd0;
            w_win[s] = {v_tag, v_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FILL;
            r_wr_ptr     <= 4'd0;
            r_fill       <= 4'd0;
            r_stride_cnt <= 4'd0;
            r_line_end   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= 16'd0;
                r_dout[i] <= 20'd0;
            end
        end else if (r_state == S_FILL) begin
            if (w_accept) begin
                r_slot[r_wr_ptr] <= s_data;
                if (w_fire) begin
                    r_state      <= S_EMIT;
                    r_wr_ptr     <= w_ptr_next;
                    r_fill       <= w_fill_next;
                    r_stride_cnt <= w_stride_next;
                    r_line_end   <= s_last;
                    for (int i = 0; i < DEPTH; i++) begin
                        r_dout[i] <= w_win[i];
                    end
                end else if (s_last) begin
                    r_wr_ptr     <= 4'd0;
                    r_fill       <= 4'd0;
                    r_stride_cnt <= 4'd0;
                end else begin
                    r_wr_ptr     <= w_ptr_next;
                    r_fill       <= w_fill_next;
                    r_stride_cnt <= w_stride_next;
                end
            end
        end else if (m_ready) begin
            r_state      <= S_FILL;
            r_stride_cnt <= 4'd0;
            // A line that ended inside the window restarts only once the window is taken.
            if (r_line_end) begin
                r_wr_ptr   <= 4'd0;
                r_fill     <= 4'd0;
                r_line_end <= 1'b0;
            end
        end
    end

    assign data_out0  = r_dout[0];
    assign data_out1  = r_dout[1];
    assign data_out2  = r_dout[2];
    assign data_out3  = r_dout[3];
    assign data_out4  = r_dout[4];
    assign data_out5  = r_dout[5];
    assign data_out6  = r_dout[6];
    assign data_out7  = r_dout[7];
    assign data_out8  = r_dout[8];
    assign data_out9  = r_dout[9];
    assign data_out10 = r_dout[10];
    assign data_out11 = r_dout[11];
    assign data_out12 = r_dout[12];
endmodule
